// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: chooses the PC source and holds, loads or flushes IF/ID based on
// branch/jump resolution in ID, load-use hazards and memory-busy stalls.
module fetch_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             iValid,
  input  logic             iBranch,
  input  logic             iTaken,
  input  logic             iJump,
  input  logic             iJumpReg,
  input  logic             iIDCache,
  input  logic             iHazard,
  input  logic             iMemBusy,
  output logic             cPCWrite,
  output logic             cWrite,
  output logic             cFlush,
  output logic [2:0]       cPCSrc,
  output logic [CNT_W-1:0] oRedirects,
  output logic [CNT_W-1:0] oStallCycles
);

  localparam logic [2:0] SrcPcPlus4   = 3'd0;
  localparam logic [2:0] SrcPcSumImm  = 3'd1;
  localparam logic [2:0] SrcSeImm26   = 3'd2;
  localparam logic [2:0] SrcReadReg1  = 3'd3;
  localparam logic [2:0] SrcIdPcPlus4 = 3'd4;
  localparam logic [2:0] FlushInit    = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {
    StRun,
    StFlush
  } state_e;

  state_e           state_q;
  logic [2:0]       flush_left_q;
  logic [CNT_W-1:0] redirects_q;
  logic [CNT_W-1:0] stalls_q;

  logic       mispredict_taken;
  logic       mispredict_not_taken;
  logic       redirect_req;
  logic [2:0] redirect_src;
  logic       do_redirect;
  logic       do_stall;

  // Correctly predicted branches fall out here: only the two disagreeing cases redirect.
  always_comb begin
    mispredict_taken     = iBranch & iTaken & ~iIDCache;
    mispredict_not_taken = iBranch & ~iTaken & iIDCache;
    redirect_req         = iValid & (iJump | iJumpReg | mispredict_taken | mispredict_not_taken);
    if (iJump) begin
      redirect_src = SrcSeImm26;
    end else if (iJumpReg) begin
      redirect_src = SrcReadReg1;
    end else if (mispredict_taken) begin
      redirect_src = SrcPcSumImm;
    end else begin
      redirect_src = SrcIdPcPlus4;
    end
  end

  always_comb begin
    do_stall    = 1'b0;
    do_redirect = 1'b0;
    if (!Reset) begin
      if (state_q == StRun) begin
        do_stall    = iMemBusy | iHazard;
        do_redirect = ~iMemBusy & ~iHazard & redirect_req;
      end else begin
        do_stall = iMemBusy;
      end
    end
  end

  always_comb begin
    cPCWrite = 1'b1;
    cWrite   = 1'b1;
    cFlush   = 1'b0;
    cPCSrc   = SrcPcPlus4;
    if (Reset) begin
      cPCWrite = 1'b0;
      cWrite   = 1'b0;
      cFlush   = 1'b1;
    end else if (state_q == StFlush) begin
      cFlush = 1'b1;
      if (iMemBusy) begin
        cPCWrite = 1'b0;
        cWrite   = 1'b0;
      end
    end else if (do_stall) begin
      cPCWrite = 1'b0;
      cWrite   = 1'b0;
    end else if (do_redirect) begin
      cFlush = 1'b1;
      cPCSrc = redirect_src;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StRun;
      flush_left_q <= 3'd0;
      redirects_q  <= '0;
      stalls_q     <= '0;
    end else begin
      if (do_stall && stalls_q != '1) begin
        stalls_q <= stalls_q + 1'b1;
      end
      if (do_redirect && redirects_q != '1) begin
        redirects_q <= redirects_q + 1'b1;
      end
      unique case (state_q)
        StRun: begin
          if (do_redirect && FLUSH_CYCLES > 1) begin
            state_q      <= StFlush;
            flush_left_q <= FlushInit;
          end
        end
        StFlush: begin
          // A busy memory freezes the flush window in place.
          if (!iMemBusy) begin
            flush_left_q <= flush_left_q - 3'd1;
            if (flush_left_q <= 3'd1) begin
              state_q <= StRun;
            end
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign oRedirects   = redirects_q;
  assign oStallCycles = stalls_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: three instances (flush 1/3/2 cycles, 16/16/4-bit counters) share
// stimulus and are compared each cycle against a rule-level reference model.
module tb_fetch_sequencer;

  localparam logic [8:0] R  = 9'h100;
  localparam logic [8:0] V  = 9'h080;
  localparam logic [8:0] B  = 9'h040;
  localparam logic [8:0] T  = 9'h020;
  localparam logic [8:0] J  = 9'h010;
  localparam logic [8:0] JR = 9'h008;
  localparam logic [8:0] C  = 9'h004;
  localparam logic [8:0] H  = 9'h002;
  localparam logic [8:0] M  = 9'h001;

  logic Clk = 1'b0;
  logic Reset, iValid, iBranch, iTaken, iJump, iJumpReg, iIDCache, iHazard, iMemBusy;

  logic        pcw0, w0, f0, pcw1, w1, f1, pcw2, w2, f2;
  logic [2:0]  src0, src1, src2;
  logic [15:0] red0, st0, red1, st1;
  logic [3:0]  red2, st2;

  logic [5:0]  got_ctl [3];
  logic [15:0] got_red [3];
  logic [15:0] got_st  [3];

  int total = 0;
  int bad   = 0;

  bit m_fl   [3];
  int m_left [3];
  int m_red  [3];
  int m_st   [3];
  int m_f    [3] = '{1, 3, 2};
  int m_max  [3] = '{65535, 65535, 15};

  always #5 Clk = ~Clk;

  fetch_sequencer #(.FLUSH_CYCLES(1), .CNT_W(16)) u_d1 (
    .Clk(Clk), .Reset(Reset), .iValid(iValid), .iBranch(iBranch), .iTaken(iTaken),
    .iJump(iJump), .iJumpReg(iJumpReg), .iIDCache(iIDCache), .iHazard(iHazard),
    .iMemBusy(iMemBusy), .cPCWrite(pcw0), .cWrite(w0), .cFlush(f0), .cPCSrc(src0),
    .oRedirects(red0), .oStallCycles(st0)
  );

  fetch_sequencer #(.FLUSH_CYCLES(3), .CNT_W(16)) u_d3 (
    .Clk(Clk), .Reset(Reset), .iValid(iValid), .iBranch(iBranch), .iTaken(iTaken),
    .iJump(iJump), .iJumpReg(iJumpReg), .iIDCache(iIDCache), .iHazard(iHazard),
    .iMemBusy(iMemBusy), .cPCWrite(pcw1), .cWrite(w1), .cFlush(f1), .cPCSrc(src1),
    .oRedirects(red1), .oStallCycles(st1)
  );

  fetch_sequencer #(.FLUSH_CYCLES(2), .CNT_W(4)) u_ds (
    .Clk(Clk), .Reset(Reset), .iValid(iValid), .iBranch(iBranch), .iTaken(iTaken),
    .iJump(iJump), .iJumpReg(iJumpReg), .iIDCache(iIDCache), .iHazard(iHazard),
    .iMemBusy(iMemBusy), .cPCWrite(pcw2), .cWrite(w2), .cFlush(f2), .cPCSrc(src2),
    .oRedirects(red2), .oStallCycles(st2)
  );

  assign got_ctl[0] = {pcw0, w0, f0, src0};
  assign got_ctl[1] = {pcw1, w1, f1, src1};
  assign got_ctl[2] = {pcw2, w2, f2, src2};
  assign got_red[0] = red0;
  assign got_red[1] = red1;
  assign got_red[2] = {12'd0, red2};
  assign got_st[0]  = st0;
  assign got_st[1]  = st1;
  assign got_st[2]  = {12'd0, st2};

  task automatic drive(input logic [8:0] v);
    {Reset, iValid, iBranch, iTaken, iJump, iJumpReg, iIDCache, iHazard, iMemBusy} = v;
  endtask

  // Target chosen by the ID instruction, 0 when it needs no redirect.
  function automatic int redir_target();
    if (!iValid) return 0;
    if (iJump) return 2;
    if (iJumpReg) return 3;
    if (iBranch && iTaken && !iIDCache) return 1;
    if (iBranch && !iTaken && iIDCache) return 4;
    return 0;
  endfunction

  function automatic logic [37:0] expected(input int k);
    logic [5:0] ctl;
    int tgt;
    tgt = redir_target();
    if (Reset) ctl = 6'b001_000;
    else if (m_fl[k]) ctl = iMemBusy ? 6'b001_000 : 6'b111_000;
    else if (iMemBusy || iHazard) ctl = 6'b000_000;
    else if (tgt != 0) ctl = {3'b111, 3'(tgt)};
    else ctl = 6'b110_000;
    return {ctl, 16'(m_red[k]), 16'(m_st[k])};
  endfunction

  function automatic logic [37:0] observed(input int k);
    return {got_ctl[k], got_red[k], got_st[k]};
  endfunction

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      if (Reset) begin
        m_fl[k] = 0; m_left[k] = 0; m_red[k] = 0; m_st[k] = 0;
      end else if (m_fl[k]) begin
        if (iMemBusy) m_st[k] = (m_st[k] < m_max[k]) ? m_st[k] + 1 : m_st[k];
        else begin
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) m_fl[k] = 0;
        end
      end else if (iMemBusy || iHazard) begin
        m_st[k] = (m_st[k] < m_max[k]) ? m_st[k] + 1 : m_st[k];
      end else if (redir_target() != 0) begin
        m_red[k] = (m_red[k] < m_max[k]) ? m_red[k] + 1 : m_red[k];
        if (m_f[k] > 1) begin
          m_fl[k] = 1;
          m_left[k] = m_f[k] - 1;
        end
      end
    end
  endtask

  task automatic adv();
    model_update();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] seq[$] = '{R, R, 9'h0, 9'h0};
    drive(R);
    for (int k = 0; k < 3; k++) begin
      m_fl[k] = 0; m_left[k] = 0; m_red[k] = 0; m_st[k] = 0;
    end
    @(posedge Clk);
    #1;
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (observed(k) !== expected(k)) begin
          bad++;
          $display("FAIL reset step%0d inst%0d got=%h want=%h", i, k, observed(k), expected(k));
        end
      end
      adv();
    end
  endtask

  task automatic test_mispredict();
    logic [8:0] seq[$] = '{R, V | B | T, 9'h0, V | B | C, 9'h0, 9'h0};
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (observed(k) !== expected(k)) begin
          bad++;
          $display("FAIL mispredict step%0d inst%0d got=%h want=%h", i, k, observed(k),
                   expected(k));
        end
      end
      adv();
    end
    total++;
    if (red0 !== 16'd2) begin
      bad++;
      $display("FAIL mispredict_count got=%0d want=2", red0);
    end
  endtask

  task automatic test_prediction_bubble();
    logic [8:0] seq[$] = '{R, V | B | T | C, B | J, J, V | B, 9'h0};
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (observed(k) !== expected(k)) begin
          bad++;
          $display("FAIL predict_bubble step%0d inst%0d got=%h want=%h", i, k, observed(k),
                   expected(k));
        end
      end
      adv();
    end
    total++;
    if (red0 !== 16'd0) begin
      bad++;
      $display("FAIL predict_bubble_count got=%0d want=0", red0);
    end
  endtask

  task automatic test_hazard();
    logic [8:0] seq[$] = '{R, V | JR | H, V | JR, 9'h0, 9'h0, 9'h0};
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (observed(k) !== expected(k)) begin
          bad++;
          $display("FAIL hazard step%0d inst%0d got=%h want=%h", i, k, observed(k), expected(k));
        end
      end
      adv();
    end
  endtask

  task automatic test_flush_busy();
    logic [8:0] seq[$] = '{R, V | J, M, V | J, 9'h0, 9'h0, 9'h0};
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (observed(k) !== expected(k)) begin
          bad++;
          $display("FAIL flush_busy step%0d inst%0d got=%h want=%h", i, k, observed(k),
                   expected(k));
        end
      end
      adv();
    end
    total++;
    if (st1 !== 16'd1 || red1 !== 16'd1) begin
      bad++;
      $display("FAIL flush_busy_counts got=%0d/%0d want=1/1", red1, st1);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 23; i++) begin
      drive(i == 0 ? R : (i < 21 ? H : 9'h0));
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (observed(k) !== expected(k)) begin
          bad++;
          $display("FAIL saturation step%0d inst%0d got=%h want=%h", i, k, observed(k),
                   expected(k));
        end
      end
      adv();
    end
    total++;
    if (st2 !== 4'd15 || st0 !== 16'd20) begin
      bad++;
      $display("FAIL saturation_count got=%0d/%0d want=15/20", st2, st0);
    end
  endtask

  task automatic test_mid_reset();
    logic [8:0] seq[$] = '{R, H, V | J, R, 9'h0, 9'h0};
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (observed(k) !== expected(k)) begin
          bad++;
          $display("FAIL mid_reset step%0d inst%0d got=%h want=%h", i, k, observed(k),
                   expected(k));
        end
      end
      adv();
    end
  endtask

  task automatic test_random();
    logic [8:0] v;
    for (int i = 0; i < 400; i++) begin
      v = 9'($urandom) & ~(R | H | M);
      if ($urandom_range(0, 99) < 2) v = v | R;
      if ($urandom_range(0, 99) < 15) v = v | H;
      if ($urandom_range(0, 99) < 20) v = v | M;
      drive(v);
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (observed(k) !== expected(k)) begin
          bad++;
          $display("FAIL random cyc%0d in=%b inst%0d got=%h want=%h", i, v, k, observed(k),
                   expected(k));
        end
      end
      adv();
    end
  endtask

  initial begin
    drive(9'h0);
    test_reset();
    test_mispredict();
    test_prediction_bubble();
    test_hazard();
    test_flush_busy();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
